// File: rtl/lib_arbiter_pkg.sv
// Shared arbiter types: the state encoding used by the group scheduler FSM.
package lib_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            valid
);

  logic [ID_W-1:0] cand [N];

  // cand[gi] is the group visited at search offset gi from ptr
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [ID_W:0] sum;
    assign sum       = {1'b0, ptr} + (ID_W+1)'(gi);
    assign cand[gi]  = (sum >= (ID_W+1)'(N)) ? ID_W'(sum - (ID_W+1)'(N)) : sum[ID_W-1:0];
  end

  always_comb begin
    winner = '0;
    valid  = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[cand[i]]) winner = cand[i];
    end
  end

endmodule

// File: rtl/grp_scheduler.sv
// Grants one pixel group at a time with round-robin fairness, a hold timeout
// and a mandatory one-cycle gap after every grant.
module grp_scheduler
  import lib_arbiter_pkg::*;
#(
  parameter int NUM_GROUPS = 4,
  parameter int TIMEOUT    = 15,
  parameter int ID_W       = $clog2(NUM_GROUPS)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NUM_GROUPS-1:0] req_i,
  input  logic [NUM_GROUPS-1:0] release_i,
  output logic [NUM_GROUPS-1:0] enable_o,
  output logic                  grp_enable_o,
  output logic [ID_W-1:0]       grp_id_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  sched_state_e          state_q, state_d;
  logic [NUM_GROUPS-1:0] enable_q, enable_d;
  logic                  grp_enable_q, grp_enable_d;
  logic [ID_W-1:0]       grp_id_q, grp_id_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

  logic [ID_W-1:0]       pick_id;
  logic                  pick_valid;
  logic [ID_W-1:0]       next_ptr;
  logic                  cur_release, cur_req, cur_expired;

  rr_pick #(
    .N    (NUM_GROUPS),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req    (req_i),
    .ptr    (ptr_q),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  assign next_ptr    = (grp_id_q == ID_W'(NUM_GROUPS - 1)) ? '0 : grp_id_q + 1'b1;
  assign cur_release = release_i[grp_id_q];
  assign cur_req     = req_i[grp_id_q];
  assign cur_expired = (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    grp_id_d   = grp_id_q;
    ptr_d      = ptr_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = SERVE;
          enable_d   = NUM_GROUPS'(1) << pick_id;
          grp_id_d   = pick_id;
          wait_cnt_d = '0;
        end
      end
      SERVE: begin
        // Priority: release, then abandonment, then timeout
        if (cur_release || !cur_req || cur_expired) begin
          state_d   = GAP;
          enable_d  = '0;
          ptr_d     = next_ptr;
          timeout_d = !cur_release && cur_req && cur_expired;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      GAP: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d  = IDLE;
        enable_d = '0;
      end
    endcase

    grp_enable_d = |enable_d;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      enable_q     <= '0;
      grp_enable_q <= 1'b0;
      grp_id_q     <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      ptr_q        <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      grp_enable_q <= grp_enable_d;
      grp_id_q     <= grp_id_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      ptr_q        <= ptr_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign enable_o     = enable_q;
  assign grp_enable_o = grp_enable_q;
  assign grp_id_o     = grp_id_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_grp_scheduler.sv
// Bench for grp_scheduler: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a grant-level model.
module tb_grp_scheduler;

  localparam int NG = 4;
  localparam int TO = 15;

  logic          clk;
  logic          reset_i;
  logic [NG-1:0] req_i;
  logic [NG-1:0] release_i;
  logic [NG-1:0] enable_o;
  logic          grp_enable_o;
  logic [1:0]    grp_id_o;
  logic          busy_o;
  logic          timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  grp_scheduler #(
    .NUM_GROUPS (NG),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .release_i    (release_i),
    .enable_o     (enable_o),
    .grp_enable_o (grp_enable_o),
    .grp_id_o     (grp_id_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Grant-level model: who owns the enable, how many cycles it has held,
  // whether we are in the post-grant gap, and where the next search starts.
  int m_owner, m_held, m_ptr, m_id;
  bit m_gap, m_to;

  function automatic void model_reset();
    m_owner = -1; m_held = 0; m_ptr = 0; m_id = 0; m_gap = 0; m_to = 0;
  endfunction

  function automatic void model_revoke();
    m_ptr   = (m_owner + 1) % NG;
    m_owner = -1;
    m_gap   = 1;
  endfunction

  function automatic void model_step(input logic [NG-1:0] req, input logic [NG-1:0] rel);
    bit found;
    m_to = 0;
    if (m_owner >= 0) begin
      if (rel[m_owner]) model_revoke();
      else if (!req[m_owner]) model_revoke();
      else if (m_held + 1 == TO) begin
        model_revoke();
        m_to = 1;
      end else m_held++;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (req != 0) begin
      found = 0;
      for (int k = 0; k < NG; k++) begin
        if (!found && req[(m_ptr + k) % NG]) begin
          m_owner = (m_ptr + k) % NG;
          found   = 1;
        end
      end
      m_id   = m_owner;
      m_held = 0;
    end
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    if (reset_i) model_reset();
    else model_step(req_i, release_i);
  end

  always @(negedge clk) begin
    if (!reset_i) begin
      check("model_enable", 32'(enable_o), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      check("model_grp_enable", 32'(grp_enable_o), 32'(m_owner >= 0));
      check("model_grp_id", 32'(grp_id_o), 32'(m_id));
      check("model_busy", 32'(busy_o), 32'((m_owner >= 0) || m_gap));
      check("model_timeout", 32'(timeout_o), 32'(m_to));
      check("enable_onehot", 32'($countones(enable_o) <= 1), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [NG-1:0] en, input logic busy, input logic to);
    check({name, "_enable"}, 32'(enable_o), 32'(en));
    check({name, "_busy"}, 32'(busy_o), 32'(busy));
    check({name, "_timeout"}, 32'(timeout_o), 32'(to));
  endtask

  task automatic do_reset();
    req_i     = '0;
    release_i = '0;
    reset_i   = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    int mode;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    reset_i   = 1'b1;
    req_i     = '0;
    release_i = '0;
    tick();
    tick();
    reset_i = 1'b0;
    expect_out("reset", 4'b0000, 1'b0, 1'b0);
    check("reset_grp_id", 32'(grp_id_o), 32'd0);

    // Single request, release on the third serve cycle
    req_i = 4'b0100;
    tick(); expect_out("single_grant", 4'b0100, 1'b1, 1'b0);
    check("single_grp_id", 32'(grp_id_o), 32'd2);
    tick();
    tick(); release_i = 4'b0100;
    tick(); expect_out("single_gap", 4'b0000, 1'b1, 1'b0);
    release_i = '0; req_i = 4'b1111;
    tick(); expect_out("single_idle", 4'b0000, 1'b0, 1'b0);
    tick(); expect_out("single_ptr3", 4'b1000, 1'b1, 1'b0);

    // Round robin over all groups
    do_reset();
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick(); expect_out("rr_grant", 4'(1 << order[g]), 1'b1, 1'b0);
      tick(); release_i = 4'(1 << order[g]);
      tick(); expect_out("rr_gap", 4'b0000, 1'b1, 1'b0);
      release_i = '0;
      tick(); expect_out("rr_idle", 4'b0000, 1'b0, 1'b0);
    end

    // Timeout after 15 held cycles
    do_reset();
    req_i = 4'b0010;
    for (int k = 1; k <= 15; k++) begin
      tick(); expect_out("to_hold", 4'b0010, 1'b1, 1'b0);
    end
    tick(); expect_out("to_pulse", 4'b0000, 1'b1, 1'b1);
    tick(); expect_out("to_idle", 4'b0000, 1'b0, 1'b0);
    tick(); expect_out("to_regrant", 4'b0010, 1'b1, 1'b0);

    // Release arrives on the timeout cycle: release wins
    for (int k = 2; k <= 14; k++) tick();
    tick(); release_i = 4'b0010;
    tick(); expect_out("rel_to_gap", 4'b0000, 1'b1, 1'b0);
    release_i = '0; req_i = 4'b0110;
    tick();
    tick(); expect_out("rel_to_ptr", 4'b0100, 1'b1, 1'b0);

    // Current group drops its request
    tick(); req_i = 4'b0010;
    tick(); expect_out("abandon_gap", 4'b0000, 1'b1, 1'b0);
    tick();
    tick(); expect_out("abandon_next", 4'b0010, 1'b1, 1'b0);

    // Reset mid-serve
    do_reset();
    req_i = 4'b1000;
    tick(); expect_out("rst_serve", 4'b1000, 1'b1, 1'b0);
    tick();
    reset_i = 1'b1;
    #1;
    expect_out("rst_async", 4'b0000, 1'b0, 1'b0);
    check("rst_async_grp_en", 32'(grp_enable_o), 32'd0);
    check("rst_async_grp_id", 32'(grp_id_o), 32'd0);
    req_i = 4'b1001;
    tick();
    tick();
    reset_i = 1'b0;
    tick(); expect_out("rst_restart", 4'b0001, 1'b1, 1'b0);

    // Randomized traffic, checked by the model every cycle
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) mode = $urandom_range(0, 3);
      if (mode == 0 || $urandom_range(0, 15) == 0) req_i = 4'($urandom_range(0, 15));
      release_i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      reset_i   = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
